// File: rtl/sca_hdlc_pkg.sv
// Shared constants and types for the SCA e-link HDLC receiver.
package sca_hdlc_pkg;

    // Raw line patterns and FCS constants
    localparam logic [7:0]  HDLC_FLAG       = 8'h7E;
    localparam logic [15:0] CRC_POLY        = 16'h8408;
    localparam logic [15:0] CRC_RESIDUE     = 16'hF0B8;

    // Smallest frame accepted at a closing flag: two data bytes plus two FCS bytes
    localparam int          MIN_FRAME_BYTES = 4;

    // Receiver framing state
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        FLAG = 2'd1,
        DATA = 2'd2
    } hdlc_state_e;

    // Meaning of one raw line bit, given the bits that preceded it
    typedef enum logic [1:0] {
        BIT_DATA  = 2'd0,
        BIT_STUFF = 2'd1,
        BIT_FLAG  = 2'd2,
        BIT_ABORT = 2'd3
    } bit_class_e;

    // hist holds the seven previous raw bits (newest in bit 0); together with
    // raw it forms the 8-bit raw history. A flag is 0111_1110 in that window,
    // an abort is the seventh 1 in a row, and a 0 after exactly five 1s is a
    // stuffed bit inserted by the transmitter.
    function automatic bit_class_e classify_bit(input logic [6:0] hist,
                                                input logic       raw);
        bit_class_e cls;
        cls = BIT_DATA;
        if ({hist, raw} == HDLC_FLAG) begin
            cls = BIT_FLAG;
        end else if (raw && (hist[5:0] == 6'h3F)) begin
            cls = BIT_ABORT;
        end else if (!raw && (hist[5:0] == 6'h1F)) begin
            cls = BIT_STUFF;
        end
        return cls;
    endfunction

endpackage

// File: rtl/sca_hdlc_rx_crc16.sv
// Per-byte update of the reflected CRC-16/CCITT FCS (LSB-first bit order).
module sca_crc16_byte
    import sca_hdlc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_v;

    // Fold the byte in and shift out eight bits, least significant first
    always_comb begin
        crc_v = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0]) begin
                crc_v = (crc_v >> 1) ^ CRC_POLY;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/sca_hdlc_rx.sv
// HDLC receiver for the GBT-SCA e-link: flag/abort detection, bit destuffing,
// LSB-first byte assembly, FCS check and framed byte output.
//
// Output handshake: DATA_VALID is a one-cycle pulse with no back-pressure;
// DATA_OUT, SOF, EOF and CRC_OK are meaningful only while DATA_VALID is high
// (CRC_OK only while EOF is high). ABORT is a separate one-cycle pulse that
// never coincides with DATA_VALID. Every output changes exactly one CLK after
// the BIT_EN sample that caused it.
module sca_hdlc_rx
    import sca_hdlc_pkg::*;
#(
    parameter int          MAX_LEN  = 64,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BIT_EN,
    input  logic        BIT_IN,
    output logic [7:0]  DATA_OUT,
    output logic        DATA_VALID,
    output logic        SOF,
    output logic        EOF,
    output logic        CRC_OK,
    output logic        ABORT,
    output hdlc_state_e STATE_DBG
);

    localparam int               CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME_BYTES);

    // Framing state and datapath registers
    hdlc_state_e       state_q;
    logic [6:0]        hist_q;       // previous raw bits, newest in bit 0
    logic [7:0]        shreg_q;      // byte under assembly, LSB arrives first
    logic [7:0]        hold_q;       // last completed byte, not yet emitted
    logic [2:0]        bit_cnt_q;
    logic [CNT_W-1:0]  byte_cnt_q;   // completed bytes in the current frame
    logic [15:0]       crc_q;        // FCS over all bytes emitted so far
    logic              sof_sent_q;   // current frame has already shown SOF

    // Registered outputs
    logic [7:0]        data_out_q;
    logic              data_valid_q;
    logic              sof_q;
    logic              eof_q;
    logic              crc_ok_q;
    logic              abort_q;

    // Combinational helpers
    bit_class_e        bit_cls;
    logic              is_flag;
    logic              is_abort;
    logic              is_data;
    logic [7:0]        byte_d;
    logic [15:0]       crc_d;
    logic              byte_done;
    logic              close_ok;
    logic              over_len;

    // The FCS always advances by the holding byte, which is the byte emitted next
    sca_crc16_byte u_crc (
        .crc_in  (crc_q),
        .byte_in (hold_q),
        .crc_out (crc_d)
    );

    // Classify the incoming raw bit and precompute byte/frame boundary conditions
    always_comb begin
        bit_cls   = classify_bit(hist_q, BIT_IN);
        is_flag   = (bit_cls == BIT_FLAG);
        is_abort  = (bit_cls == BIT_ABORT);
        is_data   = (bit_cls == BIT_DATA);
        byte_d    = {BIT_IN, shreg_q[7:1]};
        byte_done = (bit_cnt_q == 3'd7);
        // A closing flag contributes seven bits as data before it is recognised,
        // so an aligned frame ends with exactly seven bits pending.
        close_ok  = (bit_cnt_q == 3'd7) && (byte_cnt_q >= MIN_CNT);
        over_len  = (byte_cnt_q == MAX_CNT);
    end

    // Framing FSM, byte assembly, FCS tracking and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= HUNT;
            hist_q       <= '0;
            shreg_q      <= '0;
            hold_q       <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            crc_q        <= CRC_INIT;
            sof_sent_q   <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            crc_ok_q     <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            crc_ok_q     <= 1'b0;
            abort_q      <= 1'b0;

            if (BIT_EN) begin
                hist_q <= {hist_q[5:0], BIT_IN};

                if (is_abort) begin
                    // Only a frame that already showed SOF needs closing downstream
                    abort_q <= (state_q == DATA) && sof_sent_q;
                    state_q <= HUNT;
                end else begin
                    case (state_q)
                        HUNT: begin
                            if (is_flag) begin
                                state_q <= FLAG;
                            end
                        end

                        FLAG: begin
                            // A repeated flag keeps us here; the first data bit opens a frame
                            if (is_data) begin
                                state_q    <= DATA;
                                shreg_q    <= byte_d;
                                bit_cnt_q  <= 3'd1;
                                byte_cnt_q <= '0;
                                crc_q      <= CRC_INIT;
                                sof_sent_q <= 1'b0;
                            end
                        end

                        DATA: begin
                            if (is_flag) begin
                                // The closing flag also opens the next frame
                                state_q <= FLAG;
                                if (close_ok) begin
                                    data_out_q   <= hold_q;
                                    data_valid_q <= 1'b1;
                                    eof_q        <= 1'b1;
                                    crc_ok_q     <= (crc_d == CRC_RESIDUE);
                                end else begin
                                    abort_q <= sof_sent_q;
                                end
                            end else if (is_data) begin
                                shreg_q   <= byte_d;
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (byte_done) begin
                                    if (over_len) begin
                                        state_q <= HUNT;
                                        abort_q <= sof_sent_q;
                                    end else begin
                                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                                        hold_q     <= byte_d;
                                        // Emitting one byte behind keeps flag bits out of the data
                                        if (byte_cnt_q != '0) begin
                                            data_out_q   <= hold_q;
                                            data_valid_q <= 1'b1;
                                            sof_q        <= !sof_sent_q;
                                            sof_sent_q   <= 1'b1;
                                            crc_q        <= crc_d;
                                        end
                                    end
                                end
                            end
                        end

                        default: begin
                            state_q <= HUNT;
                        end
                    endcase
                end
            end
        end
    end

    assign DATA_OUT   = data_out_q;
    assign DATA_VALID = data_valid_q;
    assign SOF        = sof_q;
    assign EOF        = eof_q;
    assign CRC_OK     = crc_ok_q;
    assign ABORT      = abort_q;
    assign STATE_DBG  = state_q;

endmodule
